seg7_hex_scroller: RTL
======================

// Module: seg7_hex_scroller
// PURPOSE
//  Multi-digit successor to the single-digit animated 7-seg path. Accepts hex
//  characters over a valid/ready handshake and shifts them into an NUM_DIGITS
//  buffer (new char enters digit 0, older chars move up). Each new char is
//  revealed one segment at a time on frame ticks from clock_divider (clk60).
//  Digits are time-multiplexed onto a shared segment bus with one-hot digit selects.
// PARAMETERS
//  NUM_DIGITS  4    digits in buffer/scan, >=2
//  SCAN_DIV    1000 clk cycles per digit scan slot, >=2
//  STEP_TICKS  1    frame ticks per revealed segment, >=1
//  ACTIVE_LOW  0    1: invert seg_out and dig_out (common-anode)
// PORTS
//  clk         in  1           system clock
//  reset       in  1           synchronous, active-high
//  frame_tick  in  1           1-cycle pulse per animation frame (clk60)
//  anim_en     in  1           1: animate new char; 0: show it instantly
//  in_valid    in  1           char offered
//  in_ready    out 1           block can accept
//  in_char     in  5           [4]=blank, [3:0]=hex nibble
//  busy        out 1           animation in progress
//  anim_done   out 1           1-cycle pulse when reveal completes
//  seg_out     out 7           segments, [0]=a .. [6]=g
//  dig_out     out NUM_DIGITS  one-hot digit select, bit i = digit i
// BEHAVIOUR
//  Reset: buffer all blank, reveal mask 7'h7F, state IDLE, scan idx 0,
//   scan cnt 0, in_ready=0, busy=0, anim_done=0, seg_out/dig_out all OFF
//   (0s, or 1s when ACTIVE_LOW). Reset mid-animation aborts it; mask 7'h7F.
//  Handshake: accept when in_valid && in_ready. in_ready=1 only in IDLE
//   (registered; 1 from first cycle after reset release). in_valid while
//   in_ready=0 is ignored; no buffering. in_char sampled on accept cycle.
//  Accept: digit[i]<=digit[i-1] for i>=1, digit[0]<=decode(in_char); old
//   digit[NUM_DIGITS-1] dropped. Decode: std hex 0-F (b,d lowercase); blank=7'h00.
//  FSM IDLE->ANIM on accept with anim_en=1: mask<=7'h00, step cnt<=0, busy=1,
//   in_ready=0 next cycle. Accept with anim_en=0: mask<=7'h7F, stay IDLE.
//  ANIM: each frame_tick increments step cnt; at STEP_TICKS it clears and mask
//   sets next bit a..g (bit k after k+1 steps). On the step setting bit 6:
//   ->IDLE, anim_done=1 for 1 cycle, busy=0, in_ready=1 same next cycle.
//   7*STEP_TICKS frame ticks total. frame_tick on accept cycle does not count.
//   anim_en changes during ANIM ignored.
//  Blank char still animates (mask irrelevant, 7 steps, anim_done fires).
//  Displayed digit i = digit[i] & (i==0 ? mask : 7'h7F).
//  Scan: cnt 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and idx increments,
//   NUM_DIGITS-1 wraps to 0. seg_out/dig_out registered from idx: 1 cycle lag;
//   dig_out exactly one bit active after first post-reset cycle.
//  Widths: cnt $clog2(SCAN_DIV), idx max(1,$clog2(NUM_DIGITS)),
//   step cnt $clog2(STEP_TICKS+1). No overflow: all counters compare-and-wrap.
//  ACTIVE_LOW applies at output registers only; internal logic active-high.
// TESTING
//  1 Reset 3 cycles, release -> seg_out=0, dig_out=0 during reset; cycle 1 after
//    dig_out=4'b0001, seg_out=0; in_ready=1, busy=0.
//  2 anim_en=0, send 1,2,3,4 back-to-back -> all accepted 1/cycle; scanned seg
//    for digits 3..0 = 06,5B,4F,66; 5th char 'A' drops '1', digit0=77.
//  3 anim_en=1, STEP_TICKS=1, send 8 -> in_ready=0; after tick k digit0 seg =
//    (1<<k)-1 for k=1..7; anim_done pulses with tick 7, in_ready=1 next cycle.
//  4 in_valid held during ANIM with char 5 -> not accepted until IDLE; then 5
//    enters digit0, 8 to digit1 fully lit (7F).
//  5 Reset asserted after 3 ticks of an animation -> busy=0, buffer blank,
//    in_ready=1 after release; frame_tick on accept cycle not counted.
//  6 NUM_DIGITS=3, SCAN_DIV=4, ACTIVE_LOW=1 -> dig_out cycles 110,101,011
//    every 4 clk; blank digit gives seg_out=7'h7F.

Source files
------------

// File: rtl/seg7_hex_scroller.sv
// Multi-digit hex scroller: characters shift in over valid/ready, the newest one
// is revealed one segment per animation step, and all digits are scanned onto one bus.
module seg7_hex_scroller #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int STEP_TICKS = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  anim_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_char,
    output logic                  busy,
    output logic                  anim_done,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_out
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP_W = $clog2(STEP_TICKS + 1);

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL   = {NUM_DIGITS{ACTIVE_LOW != 0}};

    typedef enum logic {
        IDLE,
        ANIM
    } state_t;

    state_t state, state_next;

    logic                  accept;
    logic                  step_done;
    logic                  reveal_last;
    logic [6:0]            digits [NUM_DIGITS];
    logic [6:0]            mask;
    logic [STEP_W-1:0]     step_cnt;
    logic [CNT_W-1:0]      scan_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  anim_done_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic [6:0]            shown;
    logic [NUM_DIGITS-1:0] onehot;

    function automatic logic [6:0] decode(input logic [4:0] c);
        logic [6:0] s;
        if (c[4]) begin
            s = 7'h00;
        end else begin
            case (c[3:0])
                4'h0: s = 7'h3F;
                4'h1: s = 7'h06;
                4'h2: s = 7'h5B;
                4'h3: s = 7'h4F;
                4'h4: s = 7'h66;
                4'h5: s = 7'h6D;
                4'h6: s = 7'h7D;
                4'h7: s = 7'h07;
                4'h8: s = 7'h7F;
                4'h9: s = 7'h6F;
                4'hA: s = 7'h77;
                4'hB: s = 7'h7C;
                4'hC: s = 7'h39;
                4'hD: s = 7'h5E;
                4'hE: s = 7'h79;
                default: s = 7'h71;
            endcase
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = in_valid && in_ready_q;
        step_done   = 1'b0;
        reveal_last = 1'b0;
        case (state)
            IDLE: begin
                if (accept && anim_en) begin
                    state_next = ANIM;
                end
            end
            ANIM: begin
                if (frame_tick && step_cnt == STEP_LAST) begin
                    step_done = 1'b1;
                    // bits a..f already lit, so this step lights g and ends the reveal
                    if (mask[5]) begin
                        reveal_last = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask        <= '1;
            step_cnt    <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            anim_done_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
            end
        end else begin
            in_ready_q  <= (state_next == IDLE);
            busy_q      <= (state_next == ANIM);
            anim_done_q <= reveal_last;
            if (accept) begin
                for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
                    digits[i] <= digits[i-1];
                end
                digits[0] <= decode(in_char);
                mask      <= anim_en ? '0 : '1;
                step_cnt  <= '0;
            end else if (state == ANIM && frame_tick) begin
                if (step_done) begin
                    step_cnt <= '0;
                    mask     <= {mask[5:0], 1'b1};
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        shown = digits[scan_idx];
        if (scan_idx == '0) begin
            shown = digits[scan_idx] & mask;
        end
        onehot           = '0;
        onehot[scan_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            seg_q    <= SEG_POL;
            dig_q    <= DIG_POL;
        end else begin
            if (scan_cnt == CNT_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg_q <= shown ^ SEG_POL;
            dig_q <= onehot ^ DIG_POL;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign anim_done = anim_done_q;
    assign seg_out   = seg_q;
    assign dig_out   = dig_q;

endmodule
